// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator control unit: field widths, opcodes,
// FSM state encoding and the instruction-word layout.
package cu_pkg;

  localparam int OPC_W  = 3;
  localparam int IMM_W  = 5;
  localparam int DATA_W = 8;

  localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
  localparam logic [OPC_W-1:0] OP_LDI = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b011;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b100;
  localparam logic [OPC_W-1:0] OP_JZ  = 3'b101;
  localparam logic [OPC_W-1:0] OP_OUT = 3'b110;
  localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_DATA = 3'd1,
    S_DEC  = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0] op;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Fetch bus between the control unit (master) and the memory interface stage
// (slave): ctrl selects address-latch (0) or instruction-latch (1).
interface control_unit_if;

  logic                        ctrl;
  logic [cu_pkg::DATA_W-1:0]   address;
  logic [cu_pkg::DATA_W-1:0]   instruction;

  modport master (output ctrl, output address, input  instruction);
  modport slave  (input  ctrl, input  address, output instruction);

endinterface

// File: rtl/cu_alu.sv
// Combinational ALU for LDI/ADD/SUB; o_we flags opcodes that write acc/flags.
// Carry passes through unchanged for LDI and non-ALU opcodes.
module cu_alu
  import cu_pkg::*;
(
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [OPC_W-1:0]  i_op,
  input  logic              i_cf,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zf,
  output logic              o_cf,
  output logic              o_we
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Ninth bit of the difference is the borrow (set when acc < imm).
  assign w_sum  = {1'b0, i_acc} + {1'b0, i_imm};
  assign w_diff = {1'b0, i_acc} - {1'b0, i_imm};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    o_result = i_acc;
    o_cf     = i_cf;
    o_we     = 1'b0;
    case (i_op)
      OP_LDI: begin
        o_result = i_imm;
        o_we     = 1'b1;
      end
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_cf     = w_sum[DATA_W];
        o_we     = 1'b1;
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_cf     = w_diff[DATA_W];
        o_we     = 1'b1;
      end
      default: ;
    endcase
    o_zf = (o_result == '0);
  end

endmodule

// File: rtl/control_unit.sv
// Accumulator control unit: 4-cycle fetch/decode/execute FSM driving the memory
// fetch bus. Define CU_SINGLE_STEP_EN to add the step input gating S_ADDR.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [DATA_W-1:0] PC_RESET = 8'h00,
  parameter logic [DATA_W-1:0] OUT_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
`ifdef CU_SINGLE_STEP_EN
  input  logic               step,
`endif
  control_unit_if.master     mem_bus,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               halted
);

  state_t              r_state;
  instr_t              r_ir;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic                r_zf;
  logic                r_cf;
  logic                r_ctrl;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_halted;

  logic                w_advance;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_zf;
  logic                w_alu_cf;
  logic                w_alu_we;

`ifdef CU_SINGLE_STEP_EN
  assign w_advance = run & step;
`else
  assign w_advance = run;
`endif

  assign w_imm = zext_imm(r_ir.imm);

  cu_alu u_alu (
    .i_acc    (r_acc),
    .i_imm    (w_imm),
    .i_op     (r_ir.op),
    .i_cf     (r_cf),
    .o_result (w_alu_result),
    .o_zf     (w_alu_zf),
    .o_cf     (w_alu_cf),
    .o_we     (w_alu_we)
  );

  // NOTE: rst is synchronous, so it is tested inside the clocked block and not listed in the sensitivity list.
  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ADDR;
      r_ir        <= '0;
      r_pc        <= PC_RESET;
      r_acc       <= '0;
      r_zf        <= 1'b0;
      r_cf        <= 1'b0;
      r_ctrl      <= 1'b0;
      r_out_data  <= OUT_INIT;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_ADDR: begin
          if (w_advance) begin
            r_state <= S_DATA;
            r_ctrl  <= 1'b1;
          end
        end
        S_DATA: begin
          r_state <= S_DEC;
          r_ctrl  <= 1'b0;
        end
        S_DEC: begin
          r_ir    <= instr_t'(mem_bus.instruction);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_ADDR;
          r_pc    <= r_pc + 8'd1;
          if (w_alu_we) begin
            r_acc <= w_alu_result;
            r_zf  <= w_alu_zf;
            r_cf  <= w_alu_cf;
          end
          case (r_ir.op)
            OP_JMP: r_pc <= w_imm;
            OP_JZ:  if (r_zf) r_pc <= w_imm;
            OP_OUT: begin
              r_out_data  <= r_acc;
              r_out_valid <= 1'b1;
            end
            OP_HLT: begin
              r_pc     <= r_pc;
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: r_state <= S_ADDR;
      endcase
    end
  end

  assign mem_bus.ctrl    = r_ctrl;
  assign mem_bus.address = r_pc;
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;
  assign halted          = r_halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: memory model on the fetch bus plus fetch-address
// and OUT-value scoreboards filled by the stimulus and drained by a negedge monitor.
module tb_control_unit;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;

  control_unit_if cu_bus ();

  control_unit #(.PC_RESET(8'h00), .OUT_INIT(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
`ifdef CU_SINGLE_STEP_EN
    .step      (step),
`endif
    .mem_bus   (cu_bus),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Memory interface stage: latch address while ctrl=0, return the byte when ctrl=1.
  logic [7:0] mem [256];
  logic [7:0] mem_addr;
  always @(posedge clk) begin
    if (cu_bus.ctrl === 1'b1) cu_bus.instruction <= mem[mem_addr];
    else                      mem_addr <= cu_bus.address;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fetch_q[$];
  logic [7:0] out_q[$];
  bit         mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (cu_bus.ctrl === 1'b1) begin
            check("fetch_pending", fetch_q.size() > 0, 1);
            if (fetch_q.size() > 0) check("fetch_addr", cu_bus.address, fetch_q.pop_front());
          end
          if (out_valid === 1'b1) begin
            check("out_pending", out_q.size() > 0, 1);
            if (out_q.size() > 0) check("out_data", out_data, out_q.pop_front());
          end
        end
      end
    join_none

    // Reset and idle with run=0
    fill_nop();
    do_reset();
    mon_en = 1'b1;
    check("rst_ctrl", cu_bus.ctrl, 0);
    check("rst_addr", cu_bus.address, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ctrl", cu_bus.ctrl, 0);
      check("idle_addr", cu_bus.address, 8'h00);
    end

    // Fetch timing over NOPs: ctrl high one cycle in four, PC steps after S_EXEC
    for (int i = 0; i < 3; i++) fetch_q.push_back(8'(i));
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("fetch_ctrl", cu_bus.ctrl, (i % 4) == 0);
      check("fetch_addr_step", cu_bus.address, (i + 1) / 4);
    end
    do_reset();
    check("fetch_drain", fetch_q.size(), 0);

    // LDI 5, ADD 31, OUT, HLT
    mem[0] = 8'h25; mem[1] = 8'h5F; mem[2] = 8'hC0; mem[3] = 8'hE0;
    for (int i = 0; i < 4; i++) fetch_q.push_back(8'(i));
    out_q.push_back(8'h24);
    run = 1'b1;
    wait_halt(40);
    check("add_cf", dut.r_cf, 0);
    check("add_out_data", out_data, 8'h24);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_addr", cu_bus.address, 8'h03);
      check("halt_hold", halted, 1);
      check("halt_ctrl", cu_bus.ctrl, 0);
    end
    do_reset();
    check("rst_out_data_restored", out_data, 8'h00);
    check("rst_halted_clear", halted, 0);

    // LDI 3, SUB 4, OUT, HLT: borrow wraps to FF
    mem[0] = 8'h23; mem[1] = 8'h64; mem[2] = 8'hC0; mem[3] = 8'hE0;
    for (int i = 0; i < 4; i++) fetch_q.push_back(8'(i));
    out_q.push_back(8'hFF);
    run = 1'b1;
    wait_halt(40);
    check("sub_cf", dut.r_cf, 1);
    check("sub_zf", dut.r_zf, 0);
    check("sub_acc", dut.r_acc, 8'hFF);
    do_reset();

    // LDI 0, JZ 7 taken, HLT at 7
    fill_nop();
    mem[0] = 8'h20; mem[1] = 8'hA7; mem[2] = 8'hC0; mem[7] = 8'hE0;
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01); fetch_q.push_back(8'h07);
    run = 1'b1;
    wait_halt(40);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("jz_halt_addr", cu_bus.address, 8'h07);
    end
    do_reset();

    // LDI 1, JZ 7 not taken, OUT, JMP 9, HLT at 9
    fill_nop();
    mem[0] = 8'h21; mem[1] = 8'hA7; mem[2] = 8'hC0; mem[3] = 8'h89; mem[9] = 8'hE0;
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01); fetch_q.push_back(8'h02);
    fetch_q.push_back(8'h03); fetch_q.push_back(8'h09);
    out_q.push_back(8'h01);
    run = 1'b1;
    wait_halt(40);
    check("jmp_halt_addr", cu_bus.address, 8'h09);
    do_reset();

    // PC wrap: 260 NOPs back to back
    fill_nop();
    for (int i = 0; i < 260; i++) fetch_q.push_back(8'(i));
    run = 1'b1;
    for (int i = 0; i < 1040; i++) tick();
    check("wrap_addr", cu_bus.address, 8'h04);
    check("wrap_no_stall", fetch_q.size(), 0);
    do_reset();

    // Reset during S_DATA of the fetch at address 3, then a clean rerun
    fill_nop();
    mem[0] = 8'h29; mem[1] = 8'hC0; mem[4] = 8'hC0; mem[5] = 8'hE0;
    for (int i = 0; i < 4; i++) fetch_q.push_back(8'(i));
    for (int i = 0; i < 6; i++) fetch_q.push_back(8'(i));
    for (int i = 0; i < 3; i++) out_q.push_back(8'h09);
    run = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check("midop_ctrl_before", cu_bus.ctrl, 1);
    check("midop_addr_before", cu_bus.address, 8'h03);
    rst = 1'b1;
    tick();
    check("midop_addr", cu_bus.address, 8'h00);
    check("midop_ctrl", cu_bus.ctrl, 0);
    check("midop_acc", dut.r_acc, 8'h00);
    rst = 1'b0;
    wait_halt(60);
    check("midop_halt_addr", cu_bus.address, 8'h05);
    do_reset();

    // run dropped in S_DEC: OUT completes, then idle at PC 1
    fill_nop();
    mem[0] = 8'hC0;
    fetch_q.push_back(8'h00);
    out_q.push_back(8'h00);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    check("rundrop_out_valid", out_valid, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rundrop_ctrl", cu_bus.ctrl, 0);
      check("rundrop_addr", cu_bus.address, 8'h01);
    end
    do_reset();

    // Reset coinciding with S_EXEC of OUT
    mem[0] = 8'h27; mem[1] = 8'hC0;
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01);
    run = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_vs_out_valid", out_valid, 0);
    check("rst_vs_out_data", out_data, 8'h00);
    check("rst_vs_out_addr", cu_bus.address, 8'h00);
    rst = 1'b0;
    run = 1'b0;
    tick();
    check("rst_vs_out_valid_after", out_valid, 0);

    // Reset coinciding with S_EXEC of HLT
    mem[0] = 8'hE0;
    fetch_q.push_back(8'h00);
    run = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_vs_hlt_halted", halted, 0);
    check("rst_vs_hlt_addr", cu_bus.address, 8'h00);
    rst = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_vs_hlt_halted_after", halted, 0);

    check("fetch_q_empty", fetch_q.size(), 0);
    check("out_q_empty", out_q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
